// File: rtl/fsk_iq_modulator_if.sv
// Symbol handshake and I/Q sample bundle for the FSK modulator.
// The symbol source is master; the modulator is slave.
interface fsk_iq_modulator_if;
  logic               sym_valid;
  logic [3:0]         sym_data;
  logic [1:0]         mode;
  logic               sym_ready;
  logic               out_valid;
  logic signed [17:0] output_i;
  logic signed [17:0] output_q;

  modport master (
    output sym_valid, sym_data, mode,
    input  sym_ready, out_valid, output_i, output_q
  );

  modport slave (
    input  sym_valid, sym_data, mode,
    output sym_ready, out_valid, output_i, output_q
  );
endinterface

// File: rtl/fsk_iq_modulator.sv
// M-ary CPFSK I/Q source: first sample 2 clocks after accept; sym_ready only in IDLE or on a symbol's last sample.
// Define FSK_PHASE_RESET_EN to clear the phase at every accepted symbol (phase-coherent FSK).
module fsk_iq_modulator #(
  parameter int SPS       = 16,
  parameter int PHASE_W   = 16,
  parameter int HALF_STEP = 256,
  parameter int AMP       = 100000
) (
  input  logic              clk,
  input  logic              rst,
  fsk_iq_modulator_if.slave bus
);
  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
  localparam int ROM_N = 256;
  localparam int ROM_W = 17;
  localparam real PI = 3.14159265358979323846;

  // Quarter-wave table is built at elaboration from a Taylor series so it follows AMP.
  function automatic logic [ROM_N*ROM_W-1:0] build_rom();
    logic [ROM_N*ROM_W-1:0] r;
    real x, term, s;
    r = '0;
    for (int n = 0; n < ROM_N; n++) begin
      x    = (real'(n) + 0.5) * PI / 512.0;
      term = x;
      s    = x;
      for (int t = 1; t < 12; t++) begin
        term = -term * x * x / real'((2 * t) * (2 * t + 1));
        s    = s + term;
      end
      r[n*ROM_W +: ROM_W] = ROM_W'($rtoi(real'(AMP) * s + 0.5));
    end
    return r;
  endfunction

  localparam logic [ROM_N*ROM_W-1:0] ROM_FLAT = build_rom();

  function automatic logic signed [17:0] wave(input logic [9:0] idx);
    logic [7:0]       addr;
    logic [ROM_W-1:0] mag;
    addr = idx[8] ? ~idx[7:0] : idx[7:0];
    mag  = ROM_FLAT[int'(addr)*ROM_W +: ROM_W];
    return idx[9] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d, inc_new;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         mask;
  int                 tone;
  logic               ready;
  logic               valid_q;
  logic signed [17:0] i_q, q_q;
  logic [9:0]         sin_idx, cos_idx;

  always_comb begin
    mask    = 4'((2 << bus.mode) - 1);
    tone    = 2 * int'(bus.sym_data & mask) - int'(mask);
    inc_new = PHASE_W'(tone * HALF_STEP);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready   = 1'b1;
        phase_d = '0;
        if (bus.sym_valid) begin
          inc_d   = inc_new;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        phase_d = phase_q + inc_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          ready = 1'b1;
          cnt_d = '0;
          if (bus.sym_valid) begin
            inc_d = inc_new;
`ifdef FSK_PHASE_RESET_EN
            phase_d = '0;
`else
            phase_d = phase_q + inc_q;
`endif
          end else begin
            state_d = IDLE;
            phase_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      inc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
    end
  end

  // cos is sin advanced by a quarter turn (+256 in the 10-bit table index)
  assign sin_idx = phase_q[PHASE_W-1 -: 10];
  assign cos_idx = sin_idx + 10'd256;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= (state_q == RUN);
      i_q     <= (state_q == RUN) ? wave(cos_idx) : '0;
      q_q     <= (state_q == RUN) ? wave(sin_idx) : '0;
    end
  end

  assign bus.sym_ready = ready;
  assign bus.out_valid = valid_q;
  assign bus.output_i  = i_q;
  assign bus.output_q  = q_q;
endmodule

// File: tb/tb_fsk_iq_modulator.sv
// Randomised bench for fsk_iq_modulator against a trigonometric reference model.
module tb_fsk_iq_modulator;
  localparam int  SPS       = 16;
  localparam int  PHASE_W   = 16;
  localparam int  HALF_STEP = 256;
  localparam int  AMP       = 100000;
  localparam real PI        = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsk_iq_modulator_if bus();

  fsk_iq_modulator #(
    .SPS(SPS), .PHASE_W(PHASE_W), .HALF_STEP(HALF_STEP), .AMP(AMP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int stray  = 0;
  bit capture = 1'b0;
  int sd[$], sm[$], sg[$], sl[$];
  int acc_t[$], got_t[$], got_i[$], got_q[$];
  int exp_t[$], exp_i[$], exp_q[$];

  // Inputs change at posedge+1, so everything is stable at the negedge.
  always @(negedge clk) begin
    cyc++;
    if (capture) begin
      if (bus.sym_valid && bus.sym_ready) acc_t.push_back(cyc);
      if (bus.out_valid) begin
        got_t.push_back(cyc);
        got_i.push_back(int'(bus.output_i));
        got_q.push_back(int'(bus.output_q));
      end else if (bus.output_i != 0 || bus.output_q != 0) begin
        stray++;
      end
    end
  end

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic real angle(int ph);
    return (real'(ph >> (PHASE_W - 10)) + 0.5) * PI / 512.0;
  endfunction

  function automatic int ref_i(int ph);
    return rnd(real'(AMP) * $cos(angle(ph)));
  endfunction

  function automatic int ref_q(int ph);
    return rnd(real'(AMP) * $sin(angle(ph)));
  endfunction

  // Model: each accepted symbol yields SPS samples starting 2 cycles after its accept;
  // phase continues only when the next accept lands exactly SPS cycles later.
  task automatic build_expected;
    int ph, inc, m, k, prev_end;
    exp_t.delete(); exp_i.delete(); exp_q.delete();
    ph = 0;
    prev_end = -1;
    for (int j = 0; j < acc_t.size() && j < sd.size(); j++) begin
      m   = 2 << sm[j];
      k   = sd[j] % m;
      inc = (2 * k - (m - 1)) * HALF_STEP;
      if (acc_t[j] != prev_end) ph = 0;
`ifdef FSK_PHASE_RESET_EN
      ph = 0;
`endif
      for (int s = 0; s < SPS; s++) begin
        exp_t.push_back(acc_t[j] + 2 + s);
        exp_i.push_back(ref_i(ph));
        exp_q.push_back(ref_q(ph));
        ph = (ph + inc) & ((1 << PHASE_W) - 1);
      end
      prev_end = acc_t[j] + SPS;
    end
  endtask

  task automatic clear_syms;
    sd.delete(); sm.delete(); sg.delete(); sl.delete();
  endtask

  task automatic add_sym(input int d, input int m, input int g, input int l);
    sd.push_back(d); sm.push_back(m); sg.push_back(g); sl.push_back(l);
  endtask

  // Garbage data/mode is driven while the DUT is busy to show it is ignored.
  task automatic drive_seq;
    int budget;
    for (int j = 0; j < sd.size(); j++) begin
      bus.sym_valid = 1'b0;
      repeat (sg[j]) begin @(posedge clk); #1; end
      budget = 0;
      while (!bus.sym_ready && budget < 100) begin
        bus.sym_valid = (sl[j] == 0);
        bus.sym_data  = 4'($urandom);
        bus.mode      = 2'($urandom);
        @(posedge clk); #1;
        budget++;
      end
      checks++;
      if (budget >= 100) begin
        errors++;
        $display("FAIL ready_timeout symbol %0d waited %0d cycles, limit 100", j, budget);
      end
      bus.sym_valid = 1'b1;
      bus.sym_data  = 4'(sd[j]);
      bus.mode      = 2'(sm[j]);
      @(posedge clk); #1;
    end
    bus.sym_valid = 1'b0;
    bus.sym_data  = 4'($urandom);
    bus.mode      = 2'($urandom);
  endtask

  task automatic run_seq;
    acc_t.delete(); got_t.delete(); got_i.delete(); got_q.delete();
    stray = 0;
    @(posedge clk); #1;
    capture = 1'b1;
    drive_seq();
    repeat (SPS + 4) @(negedge clk);
    capture = 1'b0;
    build_expected();
  endtask

  task automatic test_reset;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 4'd0;
    bus.mode      = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.output_i !== 18'sd0 || bus.output_q !== 18'sd0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b i=%0d q=%0d rdy=%b, expected v=0 i=0 q=0 rdy=1",
               bus.out_valid, bus.output_i, bus.output_q, bus.sym_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.output_i !== 18'sd0 || bus.output_q !== 18'sd0 || bus.sym_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d got v=%b i=%0d q=%0d rdy=%b, expected 0 0 0 1",
                 c, bus.out_valid, bus.output_i, bus.output_q, bus.sym_ready);
      end
    end
  endtask

  task automatic test_2fsk;
    clear_syms();
    add_sym(1, 0, 0, 0);
    add_sym(0, 0, 0, 0);
    run_seq();
    checks++;
    if (acc_t.size() !== 2 || got_t.size() !== exp_t.size() || acc_t[1] - acc_t[0] !== SPS) begin
      errors++;
      $display("FAIL 2fsk_count accepts=%0d samples=%0d, expected 2 accepts %0d apart and %0d samples",
               acc_t.size(), got_t.size(), SPS, exp_t.size());
    end
    for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
      checks++;
      if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
        errors++;
        $display("FAIL 2fsk_sample[%0d] got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                 s, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
      end
    end
`ifndef FSK_PHASE_RESET_EN
    checks++;
    if (got_q.size() < 18 || !(got_q[16] > got_q[15] && got_q[17] < got_q[16])) begin
      errors++;
      $display("FAIL 2fsk_turnaround q15..q17 not rising then falling (samples=%0d)", got_q.size());
    end
`endif
  endtask

  task automatic test_16fsk;
    clear_syms();
    add_sym(15, 3, 0, 0);
    add_sym(0, 3, 0, 0);
    run_seq();
    checks++;
    if (acc_t.size() !== 2 || got_t.size() !== exp_t.size()) begin
      errors++;
      $display("FAIL 16fsk_count accepts=%0d samples=%0d, expected 2 and %0d", acc_t.size(), got_t.size(), exp_t.size());
    end
    for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
      checks++;
      if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
        errors++;
        $display("FAIL 16fsk_sample[%0d] got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                 s, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
      end
    end
  endtask

  task automatic test_masking;
    clear_syms();
    add_sym(4'b1110, 1, 0, 0);
    run_seq();
    checks++;
    if (got_q.size() < 2 || got_q[1] !== ref_q(256) || got_i[1] !== ref_i(256)) begin
      errors++;
      $display("FAIL mask_step second sample i=%0d q=%0d (n=%0d), expected i=%0d q=%0d",
               (got_i.size() > 1) ? got_i[1] : 0, (got_q.size() > 1) ? got_q[1] : 0, got_q.size(),
               ref_i(256), ref_q(256));
    end
    for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
      checks++;
      if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
        errors++;
        $display("FAIL mask_sample[%0d] got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                 s, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
      end
    end
  endtask

  task automatic test_gaps;
    clear_syms();
    add_sym(4'($urandom), 2'($urandom), 0, 0);
    add_sym(4'($urandom), 2'($urandom), 20, 0);
    add_sym(4'($urandom), 2'($urandom), 0, 1);
    add_sym(4'($urandom), 2'($urandom), 0, 0);
    run_seq();
    checks++;
    if (acc_t.size() < 4 || acc_t[1] - acc_t[0] <= SPS || acc_t[2] - acc_t[1] !== SPS || acc_t[3] - acc_t[2] !== SPS) begin
      errors++;
      $display("FAIL gap_accepts got %0d accepts with wrong spacing, expected 4 with idle gap then %0d-cycle spacing",
               acc_t.size(), SPS);
    end
    checks++;
    if (got_t.size() !== exp_t.size() || stray !== 0) begin
      errors++;
      $display("FAIL gap_count samples=%0d stray=%0d, expected samples=%0d stray=0", got_t.size(), stray, exp_t.size());
    end
    checks++;
    if (got_i.size() < 17 || got_i[16] !== ref_i(0) || got_q[16] !== ref_q(0)) begin
      errors++;
      $display("FAIL gap_restart second burst did not start at phase 0, expected i=%0d q=%0d", ref_i(0), ref_q(0));
    end
    for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
      checks++;
      if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
        errors++;
        $display("FAIL gap_sample[%0d] got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                 s, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.output_i !== 18'sd0 || bus.output_q !== 18'sd0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_idle got v=%b i=%0d q=%0d rdy=%b, expected 0 0 0 1",
               bus.out_valid, bus.output_i, bus.output_q, bus.sym_ready);
    end
  endtask

  task automatic test_random;
    int pick;
    for (int r = 0; r < 2; r++) begin
      clear_syms();
      for (int j = 0; j < 12; j++) begin
        pick = $urandom_range(0, 4);
        add_sym(4'($urandom), 2'($urandom), (pick == 3) ? 3 : (pick == 4) ? 20 : 0, $urandom_range(0, 1));
      end
      run_seq();
      checks++;
      if (acc_t.size() !== sd.size() || got_t.size() !== exp_t.size() || stray !== 0) begin
        errors++;
        $display("FAIL rand_count round %0d accepts=%0d samples=%0d stray=%0d, expected %0d, %0d, 0",
                 r, acc_t.size(), got_t.size(), stray, sd.size(), exp_t.size());
      end
      for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
        checks++;
        if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
          errors++;
          $display("FAIL rand_sample[%0d] round %0d got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                   s, r, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    int n, budget;
    @(posedge clk); #1;
    bus.sym_valid = 1'b1;
    bus.sym_data  = 4'($urandom);
    bus.mode      = 2'($urandom);
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    n = 0;
    budget = 0;
    while (n < 8 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (bus.out_valid) n++;
    end
    checks++;
    if (n < 8) begin
      errors++;
      $display("FAIL midrst_wait saw %0d samples in %0d cycles, expected 8", n, budget);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.output_i !== 18'sd0 || bus.output_q !== 18'sd0 || bus.sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async got v=%b i=%0d q=%0d rdy=%b, expected 0 0 0 1",
               bus.out_valid, bus.output_i, bus.output_q, bus.sym_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_syms();
    add_sym(4'($urandom), 2'($urandom), 0, 0);
    run_seq();
    checks++;
    if (got_i.size() !== SPS || got_i[0] !== ref_i(0) || got_q[0] !== ref_q(0) || stray !== 0) begin
      errors++;
      $display("FAIL midrst_restart samples=%0d first i=%0d q=%0d, expected %0d samples i=%0d q=%0d",
               got_i.size(), (got_i.size() > 0) ? got_i[0] : 0, (got_q.size() > 0) ? got_q[0] : 0,
               SPS, ref_i(0), ref_q(0));
    end
    for (int s = 0; s < exp_t.size() && s < got_t.size(); s++) begin
      checks++;
      if (got_t[s] !== exp_t[s] || got_i[s] !== exp_i[s] || got_q[s] !== exp_q[s]) begin
        errors++;
        $display("FAIL midrst_sample[%0d] got t=%0d i=%0d q=%0d, expected t=%0d i=%0d q=%0d",
                 s, got_t[s], got_i[s], got_q[s], exp_t[s], exp_i[s], exp_q[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_2fsk();
    test_16fsk();
    test_masking();
    test_gaps();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
